// File: rtl/mem_loader.sv
// Byte-stream program loader: receives a framed image and writes it through the
// shared MAR/RAM bus, optionally reading each byte back to confirm it landed.
module mem_loader #(
   parameter logic [7:0]  SYNC_BYTE = 8'h55,
   parameter bit          VERIFY_EN = 1'b1,
   parameter int unsigned TIMEOUT   = 50000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   input  logic [7:0]  in_data_i,
   output logic        in_ready_o,
   output logic        bus_req_o,
   input  logic        bus_gnt_i,
   output logic        bus_oe_o,
   output logic [15:0] bus_o,
   output logic        mar_we_o,
   output logic        ram_we_o,
   input  logic [7:0]  mem_out_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [1:0]  err_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_HDR_HI    = 4'd1;
   localparam logic [3:0] S_HDR_LO    = 4'd2;
   localparam logic [3:0] S_HDR_LEN   = 4'd3;
   localparam logic [3:0] S_DATA_WAIT = 4'd4;
   localparam logic [3:0] S_ACQ       = 4'd5;
   localparam logic [3:0] S_WR_MAR    = 4'd6;
   localparam logic [3:0] S_WR_RAM    = 4'd7;
   localparam logic [3:0] S_VERIFY    = 4'd8;
   localparam logic [3:0] S_CHK       = 4'd9;
   localparam logic [3:0] S_DONE      = 4'd10;
   localparam logic [3:0] S_ERR       = 4'd11;

   logic [3:0]    state_q, state_d;
   logic [15:0]   addr_q, addr_d;
   logic [8:0]    len_q, len_d;
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    byte_q, byte_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    err_q, err_d;

   logic       accept, timed, tmo, step;
   logic [7:0] chk_sum;

   always_comb begin
      in_ready_o = state_q inside {S_IDLE, S_HDR_HI, S_HDR_LO, S_HDR_LEN, S_DATA_WAIT, S_CHK};
      bus_req_o  = state_q inside {S_ACQ, S_WR_MAR, S_WR_RAM, S_VERIFY};
      // Strobes are gated by the grant so losing the bus kills them in the same cycle.
      mar_we_o   = (state_q == S_WR_MAR) && bus_gnt_i;
      ram_we_o   = (state_q == S_WR_RAM) && bus_gnt_i;
      bus_oe_o   = mar_we_o || ram_we_o;
      bus_o      = mar_we_o ? addr_q : (ram_we_o ? {8'h00, byte_q} : 16'h0000);
      busy_o     = (state_q != S_IDLE);
      done_o     = (state_q == S_DONE);
      err_o      = err_q;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      sum_d   = sum_q;
      byte_d  = byte_q;
      timer_d = timer_q;
      err_d   = err_q;
      step    = 1'b0;
      accept  = in_valid_i && in_ready_o;
      timed   = state_q inside {S_HDR_HI, S_HDR_LO, S_HDR_LEN, S_DATA_WAIT, S_CHK};
      tmo     = timed && !accept && (timer_q == TLAST);
      chk_sum = sum_q + in_data_i;
      if (timed) timer_d = accept ? '0 : timer_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (accept && in_data_i == SYNC_BYTE) begin
               state_d = S_HDR_HI;
               err_d   = 2'b00;
            end
         end
         S_HDR_HI: if (accept) begin
            addr_d[15:8] = in_data_i;
            state_d      = S_HDR_LO;
         end
         S_HDR_LO: if (accept) begin
            addr_d[7:0] = in_data_i;
            state_d     = S_HDR_LEN;
         end
         S_HDR_LEN: if (accept) begin
            len_d   = (in_data_i == 8'h00) ? 9'd256 : {1'b0, in_data_i};
            sum_d   = 8'h00;
            state_d = S_DATA_WAIT;
         end
         S_DATA_WAIT: if (accept) begin
            byte_d  = in_data_i;
            sum_d   = chk_sum;
            state_d = S_ACQ;
         end
         S_ACQ:    if (bus_gnt_i) state_d = S_WR_MAR;
         S_WR_MAR: state_d = bus_gnt_i ? S_WR_RAM : S_ACQ;
         S_WR_RAM: begin
            if (!bus_gnt_i)     state_d = S_ACQ;
            else if (VERIFY_EN) state_d = S_VERIFY;
            else                step    = 1'b1;
         end
         S_VERIFY: begin
            if (!bus_gnt_i) state_d = S_ACQ;
            else if (mem_out_i != byte_q) begin
               state_d = S_ERR;
               err_d   = 2'b10;
            end else step = 1'b1;
         end
         S_CHK: if (accept) begin
            if (chk_sum == 8'h00) state_d = S_DONE;
            else begin
               state_d = S_ERR;
               err_d   = 2'b01;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Byte committed: advance the write pointer, wrapping at the top of memory.
      if (step) begin
         addr_d  = addr_q + 16'd1;
         len_d   = len_q - 9'd1;
         state_d = (len_q == 9'd1) ? S_CHK : S_DATA_WAIT;
      end
      if (tmo) begin
         state_d = S_ERR;
         err_d   = 2'b11;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         sum_q   <= '0;
         byte_q  <= '0;
         timer_q <= '0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         byte_q  <= byte_d;
         timer_q <= timer_d;
         err_q   <= err_d;
      end
   end

endmodule
